// File: rtl/fft_cache_rd_arb_pkg.sv
// fft_cache_rd_arb_pkg: shared burst FSM states, source IDs and read tag layout
package fft_cache_rd_arb_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} burst_st_t;
   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;
   typedef struct packed {
      logic vld;
      logic src;
      logic chnl;
   } rd_tag_t;
endpackage

// File: rtl/fft_cache_rd_arb_if.sv
// fft_cache_rd_arb_if: requester A, display burst B and result-RAM signals of the read arbiter
interface fft_cache_rd_arb_if #(parameter int P_FFT_RAM_ADDR_W = 7, parameter int P_FFT_RAM_DATA_W = 32);
   logic                          fft_busy_ih;
   logic                          a_req_ih;
   logic [P_FFT_RAM_ADDR_W-1:0]   a_addr_id;
   logic                          a_chnl_id;
   logic                          a_gnt_oh;
   logic [P_FFT_RAM_DATA_W-1:0]   a_rdata_od;
   logic                          a_rdata_valid_oh;
   logic                          b_start_ih;
   logic [P_FFT_RAM_ADDR_W-1:0]   b_base_addr_id;
   logic [P_FFT_RAM_ADDR_W:0]     b_len_id;
   logic                          b_chnl_id;
   logic                          b_busy_oh;
   logic [P_FFT_RAM_DATA_W-1:0]   b_rdata_od;
   logic                          b_rdata_valid_oh;
   logic                          b_done_oh;
   logic [P_FFT_RAM_ADDR_W-1:0]   fft_res_ram_rd_addr_od;
   logic [P_FFT_RAM_DATA_W-1:0]   fft_res_ram_lchnl_data_id;
   logic [P_FFT_RAM_DATA_W-1:0]   fft_res_ram_rchnl_data_id;
   modport master (
      output fft_busy_ih, a_req_ih, a_addr_id, a_chnl_id, b_start_ih, b_base_addr_id, b_len_id, b_chnl_id,
             fft_res_ram_lchnl_data_id, fft_res_ram_rchnl_data_id,
      input  a_gnt_oh, a_rdata_od, a_rdata_valid_oh, b_busy_oh, b_rdata_od, b_rdata_valid_oh, b_done_oh,
             fft_res_ram_rd_addr_od
   );
   modport slave (
      input  fft_busy_ih, a_req_ih, a_addr_id, a_chnl_id, b_start_ih, b_base_addr_id, b_len_id, b_chnl_id,
             fft_res_ram_lchnl_data_id, fft_res_ram_rchnl_data_id,
      output a_gnt_oh, a_rdata_od, a_rdata_valid_oh, b_busy_oh, b_rdata_od, b_rdata_valid_oh, b_done_oh,
             fft_res_ram_rd_addr_od
   );
endinterface

// File: rtl/fft_cache_burst_gen.sv
// fft_cache_burst_gen: display burst address/count FSM; tracks outstanding issues and returns
module fft_cache_burst_gen import fft_cache_rd_arb_pkg::*; #(
   parameter int P_FFT_RAM_ADDR_W = 7
) (
   input  logic                        av_clk_ir,
   input  logic                        av_rst_ih,
   input  logic                        start,
   input  logic [P_FFT_RAM_ADDR_W-1:0] base,
   input  logic [P_FFT_RAM_ADDR_W:0]   len,
   input  logic                        chnl,
   input  logic                        gnt,
   input  logic                        ret,
   output logic                        issue,
   output logic [P_FFT_RAM_ADDR_W-1:0] addr,
   output logic                        burst_chnl,
   output logic                        busy,
   output logic                        done
);
   localparam int AW = P_FFT_RAM_ADDR_W;
   localparam int LW = P_FFT_RAM_ADDR_W + 1;
   burst_st_t st;
   logic [LW-1:0] iss_cnt, ret_cnt;
   logic last_ret;
   assign issue = st == ST_ISSUE;
   assign busy = st != ST_IDLE;
   assign last_ret = ret & ret_cnt == LW'(1);
   always_ff @(posedge av_clk_ir or posedge av_rst_ih)
      if (av_rst_ih) begin
         st <= ST_IDLE;
         addr <= '0;
         burst_chnl <= 1'b0;
         iss_cnt <= '0;
         ret_cnt <= '0;
         done <= 1'b0;
      end else begin
         done <= last_ret;
         if (ret) ret_cnt <= ret_cnt - LW'(1);
         case (st)
            ST_IDLE: if (start & |len) begin
               st <= ST_ISSUE;
               addr <= base;
               burst_chnl <= chnl;
               iss_cnt <= len;
               ret_cnt <= len;
            end
            ST_ISSUE: if (gnt) begin
               addr <= addr + AW'(1);
               iss_cnt <= iss_cnt - LW'(1);
               if (iss_cnt == LW'(1)) st <= ST_DRAIN;
            end
            ST_DRAIN: if (last_ret) st <= ST_IDLE;
            default: st <= ST_IDLE;
         endcase
      end
endmodule

// File: rtl/fft_cache_rd_arb.sv
// fft_cache_rd_arb: round-robin arbiter between single reads (A) and display bursts (B)
// onto the shared FFT result RAM read port, with a tag pipe routing returned data.
module fft_cache_rd_arb import fft_cache_rd_arb_pkg::*; #(
   parameter int P_FFT_RAM_ADDR_W = 7,
   parameter int P_FFT_RAM_DATA_W = 32,
   parameter int P_RD_DELAY = 2
) (
   input logic               av_clk_ir,
   input logic               av_rst_ih,
   fft_cache_rd_arb_if.slave bus
);
   logic a_el, b_el, gnt_a, gnt_b, issue, last_src, b_issue, b_ret, b_chnl;
   logic [P_FFT_RAM_ADDR_W-1:0] b_addr, rd_addr_q;
   logic [P_FFT_RAM_DATA_W-1:0] rsel;
   rd_tag_t tag_q [P_RD_DELAY];
   rd_tag_t tag_out;
   // Reset gates eligibility so the combinational grant and address are quiet in reset
   assign a_el = bus.a_req_ih & ~bus.fft_busy_ih & ~av_rst_ih;
   assign b_el = b_issue & ~bus.fft_busy_ih;
   assign gnt_a = a_el & (~b_el | last_src == SRC_B);
   assign gnt_b = b_el & ~gnt_a;
   assign issue = gnt_a | gnt_b;
   assign bus.a_gnt_oh = gnt_a;
   assign bus.fft_res_ram_rd_addr_od = gnt_a ? bus.a_addr_id : gnt_b ? b_addr : rd_addr_q;
   assign tag_out = tag_q[P_RD_DELAY-1];
   assign b_ret = tag_out.vld & tag_out.src == SRC_B;
   assign rsel = tag_out.chnl ? bus.fft_res_ram_lchnl_data_id : bus.fft_res_ram_rchnl_data_id;
   fft_cache_burst_gen #(.P_FFT_RAM_ADDR_W(P_FFT_RAM_ADDR_W)) u_burst (
      .av_clk_ir  (av_clk_ir),
      .av_rst_ih  (av_rst_ih),
      .start      (bus.b_start_ih),
      .base       (bus.b_base_addr_id),
      .len        (bus.b_len_id),
      .chnl       (bus.b_chnl_id),
      .gnt        (gnt_b),
      .ret        (b_ret),
      .issue      (b_issue),
      .addr       (b_addr),
      .burst_chnl (b_chnl),
      .busy       (bus.b_busy_oh),
      .done       (bus.b_done_oh)
   );
   always_ff @(posedge av_clk_ir or posedge av_rst_ih)
      if (av_rst_ih) begin
         last_src <= SRC_B;
         rd_addr_q <= '0;
         for (int i = 0; i < P_RD_DELAY; i++) tag_q[i] <= '0;
         bus.a_rdata_od <= '0;
         bus.a_rdata_valid_oh <= 1'b0;
         bus.b_rdata_od <= '0;
         bus.b_rdata_valid_oh <= 1'b0;
      end else begin
         if (issue) begin
            last_src <= gnt_b ? SRC_B : SRC_A;
            rd_addr_q <= bus.fft_res_ram_rd_addr_od;
         end
         tag_q[0] <= '{vld: issue, src: gnt_b, chnl: gnt_a ? bus.a_chnl_id : b_chnl};
         for (int i = 1; i < P_RD_DELAY; i++) tag_q[i] <= tag_q[i-1];
         bus.a_rdata_valid_oh <= tag_out.vld & tag_out.src == SRC_A;
         bus.b_rdata_valid_oh <= b_ret;
         if (tag_out.vld & tag_out.src == SRC_A) bus.a_rdata_od <= rsel;
         if (b_ret) bus.b_rdata_od <= rsel;
      end
endmodule

// File: tb/tb_fft_cache_rd_arb.sv
// tb_fft_cache_rd_arb: directed scenarios plus random traffic checked against a queue-based model
module tb_fft_cache_rd_arb;
   localparam int AW = 7;
   localparam int DW = 32;
   localparam int D = 2;
   logic av_clk_ir = 1'b0;
   logic av_rst_ih = 1'b1;
   always #5 av_clk_ir = ~av_clk_ir;

   fft_cache_rd_arb_if #(.P_FFT_RAM_ADDR_W(AW), .P_FFT_RAM_DATA_W(DW)) bus ();
   fft_cache_rd_arb #(.P_FFT_RAM_ADDR_W(AW), .P_FFT_RAM_DATA_W(DW), .P_RD_DELAY(D)) dut (
      .av_clk_ir (av_clk_ir),
      .av_rst_ih (av_rst_ih),
      .bus       (bus)
   );

   // two-cycle result RAM: address registered, then data registered
   logic [DW-1:0] lram [128];
   logic [DW-1:0] rram [128];
   logic [AW-1:0] ram_a1;
   always @(posedge av_clk_ir) begin
      ram_a1 <= bus.fft_res_ram_rd_addr_od;
      bus.fft_res_ram_lchnl_data_id <= lram[ram_a1];
      bus.fft_res_ram_rchnl_data_id <= rram[ram_a1];
   end

   typedef struct {
      int            due;
      bit            src;
      logic [DW-1:0] data;
      bit            done;
   } ret_t;
   ret_t pend[$];
   int cyc = 0, errors = 0, checks = 0;
   int b_rem, b_addr_m, m_hold, exp_addr;
   int nav, nbv, ndone, done_nv;
   bit m_last, b_chnl_m, e_ga, ea, eb, ga, gb, busy_m, av, bv, bd;
   logic [DW-1:0] m_ar, m_br;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge av_clk_ir);
      #1;
   endtask

   // model: grants by round-robin rule, returns scheduled D+1 cycles after issue
   always @(negedge av_clk_ir) begin
      if (av_rst_ih) begin
         chk("rst_a_gnt", bus.a_gnt_oh, 0);
         chk("rst_a_valid", bus.a_rdata_valid_oh, 0);
         chk("rst_b_valid", bus.b_rdata_valid_oh, 0);
         chk("rst_b_done", bus.b_done_oh, 0);
         chk("rst_b_busy", bus.b_busy_oh, 0);
         chk("rst_a_rdata", bus.a_rdata_od, 0);
         chk("rst_b_rdata", bus.b_rdata_od, 0);
         chk("rst_rd_addr", bus.fft_res_ram_rd_addr_od, 0);
         pend.delete();
         m_last = 1;
         b_rem = 0;
         m_hold = 0;
         m_ar = '0;
         m_br = '0;
         e_ga = 0;
      end else begin
         av = 0;
         bv = 0;
         bd = 0;
         while (pend.size() > 0 && pend[0].due == cyc) begin
            if (pend[0].src) begin
               bv = 1;
               bd = pend[0].done;
               m_br = pend[0].data;
            end else begin
               av = 1;
               m_ar = pend[0].data;
            end
            void'(pend.pop_front());
         end
         busy_m = b_rem > 0;
         foreach (pend[i]) if (pend[i].src) busy_m = 1;
         ea = bus.a_req_ih && !bus.fft_busy_ih;
         eb = b_rem > 0 && !bus.fft_busy_ih;
         ga = ea && (!eb || m_last);
         gb = eb && !ga;
         exp_addr = ga ? int'(bus.a_addr_id) : gb ? b_addr_m : m_hold;
         chk("a_gnt", bus.a_gnt_oh, ga);
         chk("rd_addr", bus.fft_res_ram_rd_addr_od, exp_addr);
         chk("a_valid", bus.a_rdata_valid_oh, av);
         chk("a_rdata", bus.a_rdata_od, m_ar);
         chk("b_valid", bus.b_rdata_valid_oh, bv);
         chk("b_rdata", bus.b_rdata_od, m_br);
         chk("b_done", bus.b_done_oh, bd);
         chk("b_busy", bus.b_busy_oh, busy_m);
         if (bus.a_rdata_valid_oh) nav++;
         if (bus.b_rdata_valid_oh) nbv++;
         if (bus.b_done_oh) begin
            ndone++;
            done_nv = nbv;
         end
         e_ga = ga;
         if (ga) begin
            pend.push_back('{cyc + D + 1, 1'b0, bus.a_chnl_id ? lram[bus.a_addr_id] : rram[bus.a_addr_id], 1'b0});
            m_last = 0;
            m_hold = exp_addr;
         end
         if (gb) begin
            pend.push_back('{cyc + D + 1, 1'b1, b_chnl_m ? lram[b_addr_m] : rram[b_addr_m], b_rem == 1});
            m_last = 1;
            m_hold = exp_addr;
            b_addr_m = (b_addr_m + 1) % 128;
            b_rem--;
         end
         if (bus.b_start_ih && !busy_m && bus.b_len_id != 0) begin
            b_rem = int'(bus.b_len_id);
            b_addr_m = int'(bus.b_base_addr_id);
            b_chnl_m = bus.b_chnl_id;
         end
      end
      cyc++;
   end

   task automatic clr_cnt();
      nav = 0;
      nbv = 0;
      ndone = 0;
      done_nv = 0;
   endtask

   logic [15:0] gpat;
   int busy_left;

   initial begin
      for (int i = 0; i < 128; i++) begin
         lram[i] = $urandom;
         rram[i] = $urandom;
      end
      lram[5] = 32'hDEADBEEF;
      bus.fft_busy_ih = 0;
      bus.a_req_ih = 0;
      bus.a_addr_id = '0;
      bus.a_chnl_id = 0;
      bus.b_start_ih = 0;
      bus.b_base_addr_id = '0;
      bus.b_len_id = '0;
      bus.b_chnl_id = 0;
      clr_cnt();
      repeat (3) tick();
      av_rst_ih = 0;
      repeat (2) tick();

      // single A read: grant in T, data with valid in T+3
      bus.a_req_ih = 1;
      bus.a_addr_id = 7'd5;
      bus.a_chnl_id = 1;
      #2 chk("a_only_gnt", bus.a_gnt_oh, 1);
      tick();
      bus.a_req_ih = 0;
      repeat (2) tick();
      #1;
      chk("a_only_valid", bus.a_rdata_valid_oh, 1);
      chk("a_only_data", bus.a_rdata_od, 32'hDEADBEEF);
      repeat (3) tick();

      // wrapping burst 126,127,0,1 on R channel
      clr_cnt();
      bus.b_start_ih = 1;
      bus.b_base_addr_id = 7'd126;
      bus.b_len_id = 8'd4;
      bus.b_chnl_id = 0;
      tick();
      bus.b_start_ih = 0;
      for (int i = 0; i < 4; i++) begin
         #1 chk("burst_addr", bus.fft_res_ram_rd_addr_od, (126 + i) % 128);
         tick();
      end
      repeat (6) tick();
      chk("burst_nvalid", nbv, 4);
      chk("burst_ndone", ndone, 1);
      chk("burst_done_at", done_nv, 4);

      // contention: A held during an 8-word burst
      clr_cnt();
      bus.b_start_ih = 1;
      bus.b_base_addr_id = 7'd40;
      bus.b_len_id = 8'd8;
      bus.b_chnl_id = 1;
      bus.a_req_ih = 1;
      bus.a_addr_id = 7'($urandom);
      bus.a_chnl_id = 1'($urandom);
      for (int i = 0; i < 16; i++) begin
         #1 gpat[i] = bus.a_gnt_oh;
         tick();
         bus.b_start_ih = 0;
         bus.a_addr_id = 7'($urandom);
         bus.a_chnl_id = 1'($urandom);
      end
      bus.a_req_ih = 0;
      chk("contention_pattern", gpat, 16'h5555);
      chk("contention_busy_tail", bus.b_busy_oh, 1);
      repeat (8) tick();
      chk("contention_nvalid", nbv, 8);
      chk("contention_done_at", done_nv, 8);
      chk("contention_a_valid", nav, 8);

      // fft_busy window mid-burst
      clr_cnt();
      bus.b_start_ih = 1;
      bus.b_base_addr_id = 7'($urandom);
      bus.b_len_id = 8'd12;
      bus.b_chnl_id = 1;
      tick();
      bus.b_start_ih = 0;
      repeat (4) tick();
      bus.fft_busy_ih = 1;
      bus.a_req_ih = 1;
      bus.a_addr_id = 7'd9;
      bus.a_chnl_id = 0;
      for (int i = 0; i < 10; i++) begin
         #1 chk("busy_no_gnt", bus.a_gnt_oh, 0);
         tick();
      end
      bus.fft_busy_ih = 0;
      repeat (4) begin
         tick();
         if (e_ga) bus.a_req_ih = 0;
      end
      repeat (30) tick();
      chk("busy_nvalid", nbv, 12);
      chk("busy_ndone", ndone, 1);
      chk("busy_a_valid", nav, 1);

      // reset one cycle after an A grant
      bus.a_req_ih = 1;
      bus.a_addr_id = 7'd77;
      tick();
      bus.a_req_ih = 0;
      av_rst_ih = 1;
      tick();
      av_rst_ih = 0;
      clr_cnt();
      repeat (6) tick();
      chk("rst_drop_a_valid", nav, 0);
      chk("rst_fsm_idle", bus.b_busy_oh, 0);
      bus.b_start_ih = 1;
      bus.b_base_addr_id = 7'd3;
      bus.b_len_id = 8'd2;
      tick();
      bus.b_start_ih = 0;
      bus.a_req_ih = 1;
      bus.a_addr_id = 7'd11;
      #1 chk("rr_after_rst", bus.a_gnt_oh, 1);
      tick();
      bus.a_req_ih = 0;
      repeat (10) tick();

      // random traffic
      busy_left = 0;
      for (int c = 0; c < 4000; c++) begin
         if (bus.a_req_ih && e_ga) bus.a_req_ih = 0;
         if (!bus.a_req_ih && $urandom_range(0, 2) == 0) begin
            bus.a_req_ih = 1;
            bus.a_addr_id = 7'($urandom);
            bus.a_chnl_id = 1'($urandom);
         end
         bus.b_start_ih = $urandom_range(0, 15) == 0;
         bus.b_base_addr_id = 7'($urandom);
         bus.b_len_id = $urandom_range(0, 9) == 0 ? 8'd128 : $urandom_range(0, 7) == 0 ? 8'd0 : 8'($urandom_range(1, 20));
         bus.b_chnl_id = 1'($urandom);
         if (busy_left > 0) busy_left--;
         else if ($urandom_range(0, 39) == 0) busy_left = $urandom_range(1, 12);
         bus.fft_busy_ih = busy_left > 0;
         av_rst_ih = c == 2000;
         tick();
      end
      av_rst_ih = 0;
      bus.a_req_ih = 0;
      bus.b_start_ih = 0;
      bus.fft_busy_ih = 0;
      repeat (300) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
